// File: rtl/sweep_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_counter
//  Description : Single-axis servo sweep counter for tracker calibration.
//                On EN it drives the forward move enable for CNT_MAX+1 cycles
//                or until PWM_LIMIT_HI. With BIDIR=1 it then drives the reverse
//                enable in the same way, up to PWM_LIMIT_LO. A completed sweep
//                gives a one-cycle DONE pulse and then holds until EN drops.
//                Dropping EN mid-sweep aborts without DONE.
//  Ports       : CLK          - system clock, rising edge
//                RST_N        - synchronous reset, active-low
//                EN           - sweep enable (level)
//                PWM_LIMIT_HI - servo at forward limit
//                PWM_LIMIT_LO - servo at reverse limit
//                CNT_FWD      - forward move enable (registered)
//                CNT_REV      - reverse move enable (registered)
//                BUSY         - CNT_FWD | CNT_REV (registered)
//                DONE         - one-cycle completion pulse (registered)
//                COUNT        - current leg count (registered)
//                LIMIT_HIT    - leg ended on a PWM limit (SWEEP_LIMIT_FLAG_EN)
//  Options     : `define SWEEP_LIMIT_FLAG_EN adds the LIMIT_HIT output
//  Revision    : 1.0 - initial release
// ============================================================================
module sweep_counter #(
  parameter int CNT_W   = 9,
  parameter int CNT_MAX = 511,
  parameter int BIDIR   = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             PWM_LIMIT_HI,
  input  logic             PWM_LIMIT_LO,
  output logic             CNT_FWD,
  output logic             CNT_REV,
  output logic             BUSY,
  output logic             DONE,
`ifdef SWEEP_LIMIT_FLAG_EN
  output logic             LIMIT_HIT,
`endif
  output logic [CNT_W-1:0] COUNT
);

  localparam logic [1:0] c_state_idle = 2'd0;
  localparam logic [1:0] c_state_fwd  = 2'd1;
  localparam logic [1:0] c_state_rev  = 2'd2;
  localparam logic [1:0] c_state_hold = 2'd3;

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_MAX[CNT_W-1:0];
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_zero = '0;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fwd_q, fwd_d;
  logic             rev_q, rev_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             limit_q, limit_d;

  logic at_max;
  logic leg_limit;

  assign at_max = (count_q == c_cnt_max);
  // Each leg listens only to the limit in its own direction.
  assign leg_limit = (state_q == c_state_fwd) ? PWM_LIMIT_HI : PWM_LIMIT_LO;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    limit_d = limit_q;

    case (state_q)
      c_state_idle: begin
        count_d = c_cnt_zero;
        if (EN) begin
          state_d = c_state_fwd;
          limit_d = 1'b0;
        end
      end

      c_state_fwd, c_state_rev: begin
        if (!EN) begin
          // Abort takes priority over any terminal condition.
          state_d = c_state_idle;
          count_d = c_cnt_zero;
        end else if (at_max || leg_limit) begin
          limit_d = limit_q | leg_limit;
          if ((state_q == c_state_fwd) && (BIDIR != 0)) begin
            state_d = c_state_rev;
            count_d = c_cnt_zero;
          end else begin
            // COUNT stays at its terminal value while holding.
            state_d = c_state_hold;
            done_d  = 1'b1;
          end
        end else begin
          count_d = count_q + c_cnt_one;
        end
      end

      default: begin // hold
        if (!EN) begin
          state_d = c_state_idle;
          count_d = c_cnt_zero;
        end
      end
    endcase

    fwd_d  = (state_d == c_state_fwd);
    rev_d  = (state_d == c_state_rev);
    busy_d = fwd_d | rev_d;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= c_state_idle;
      count_q <= c_cnt_zero;
      fwd_q   <= 1'b0;
      rev_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      fwd_q   <= fwd_d;
      rev_q   <= rev_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      limit_q <= limit_d;
    end
  end

  assign CNT_FWD = fwd_q;
  assign CNT_REV = rev_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign COUNT   = count_q;

`ifdef SWEEP_LIMIT_FLAG_EN
  assign LIMIT_HIT = limit_q;
`else
  // Flag is tracked but not exported in this build.
  logic unused_limit;
  assign unused_limit = limit_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sweep_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sweep_counter
//  Description : Bench for sweep_counter. Three instances share the stimulus:
//                CNT_MAX=7 forward-only, CNT_MAX=7 bidirectional, and
//                CNT_MAX=0 bidirectional. Outputs are compared every cycle
//                against a leg-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sweep_counter;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic       HI;
  logic       LO;
  logic [2:0] fwd, rev, busy, done;
  logic [8:0] cnt [3];
`ifdef SWEEP_LIMIT_FLAG_EN
  logic [2:0] lim;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: which leg is running (0 none, 1 forward, 2 reverse),
  // whether the sweep is parked after completion, and the leg's cycle index.
  int cmax  [3] = '{7, 7, 0};
  int bidir [3] = '{0, 1, 1};
  int m_leg [3];
  int m_cnt [3];
  bit m_hold[3];
  bit m_done[3];
  bit m_lim [3];

  sweep_counter #(.CNT_W(9), .CNT_MAX(7), .BIDIR(0)) u_fwd (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .PWM_LIMIT_HI(HI), .PWM_LIMIT_LO(LO),
    .CNT_FWD(fwd[0]), .CNT_REV(rev[0]), .BUSY(busy[0]), .DONE(done[0]),
`ifdef SWEEP_LIMIT_FLAG_EN
    .LIMIT_HIT(lim[0]),
`endif
    .COUNT(cnt[0]));

  sweep_counter #(.CNT_W(9), .CNT_MAX(7), .BIDIR(1)) u_bid (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .PWM_LIMIT_HI(HI), .PWM_LIMIT_LO(LO),
    .CNT_FWD(fwd[1]), .CNT_REV(rev[1]), .BUSY(busy[1]), .DONE(done[1]),
`ifdef SWEEP_LIMIT_FLAG_EN
    .LIMIT_HIT(lim[1]),
`endif
    .COUNT(cnt[1]));

  sweep_counter #(.CNT_W(9), .CNT_MAX(0), .BIDIR(1)) u_zero (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .PWM_LIMIT_HI(HI), .PWM_LIMIT_LO(LO),
    .CNT_FWD(fwd[2]), .CNT_REV(rev[2]), .BUSY(busy[2]), .DONE(done[2]),
`ifdef SWEEP_LIMIT_FLAG_EN
    .LIMIT_HIT(lim[2]),
`endif
    .COUNT(cnt[2]));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      m_done[i] = 1'b0;
      if (!RST_N) begin
        m_leg[i] = 0; m_cnt[i] = 0; m_hold[i] = 1'b0; m_lim[i] = 1'b0;
      end else if (m_hold[i]) begin
        if (!EN) begin m_hold[i] = 1'b0; m_cnt[i] = 0; end
      end else if (m_leg[i] == 0) begin
        if (EN) begin m_leg[i] = 1; m_cnt[i] = 0; m_lim[i] = 1'b0; end
      end else if (!EN) begin
        m_leg[i] = 0; m_cnt[i] = 0;
      end else begin
        bit stop_lim;
        stop_lim = (m_leg[i] == 1) ? HI : LO;
        if (m_cnt[i] == cmax[i] || stop_lim) begin
          if (stop_lim) m_lim[i] = 1'b1;
          if (m_leg[i] == 1 && bidir[i] == 1) begin
            m_leg[i] = 2; m_cnt[i] = 0;
          end else begin
            m_leg[i] = 0; m_hold[i] = 1'b1; m_done[i] = 1'b1;
          end
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  endtask

  // One clock: apply inputs, clock, advance model, then compare 1ns later.
  task automatic cyc(input bit rst_n, input bit en, input bit hi, input bit lo);
    RST_N = rst_n; EN = en; HI = hi; LO = lo;
    @(posedge CLK);
    model_step();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fwd%0d", i),  fwd[i],  m_leg[i] == 1);
      chk($sformatf("rev%0d", i),  rev[i],  m_leg[i] == 2);
      chk($sformatf("busy%0d", i), busy[i], m_leg[i] != 0);
      chk($sformatf("done%0d", i), done[i], m_done[i]);
      chk($sformatf("count%0d", i), cnt[i], m_cnt[i]);
`ifdef SWEEP_LIMIT_FLAG_EN
      chk($sformatf("limit%0d", i), lim[i], m_lim[i]);
`endif
    end
  endtask

  initial begin
    int fwd_len, rev_len, zfwd_len, done_n;
    RST_N = 1'b0; EN = 1'b0; HI = 1'b0; LO = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_leg[i] = 0; m_cnt[i] = 0; m_hold[i] = 0; m_done[i] = 0; m_lim[i] = 0;
    end

    // Reset for 3 cycles, with EN high on the last to prove reset wins.
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);

    // Basic and bidirectional sweeps with EN held high.
    fwd_len = 0; rev_len = 0; zfwd_len = 0; done_n = 0;
    for (int k = 0; k < 24; k++) begin
      cyc(1, 1, 0, 0);
      fwd_len  += int'(fwd[0]);
      rev_len  += int'(rev[1]);
      zfwd_len += int'(fwd[2]);
      done_n   += int'(done[0]);
    end
    chk("fwd_len_max7", fwd_len, 8);
    chk("rev_len_max7", rev_len, 8);
    chk("fwd_len_max0", zfwd_len, 1);
    chk("done_pulses", done_n, 1);
    chk("hold_count", cnt[0], 7);

    // Forward limit at COUNT=3.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0);
    chk("count_before_limit", cnt[0], 3);
    cyc(1, 1, 1, 0);
    chk("fwd_dropped_on_limit", fwd[0], 0);
    chk("rev_entered_on_limit", rev[1], 1);
    for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0);

    // Abort at COUNT=5, then a fresh sweep.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 1, 0, 0);

    // Mid-sweep reset while the bidirectional unit is at REV COUNT=4.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 13; k++) cyc(1, 1, 0, 0);
    chk("rev_count_before_reset", cnt[1], 4);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);

    // EN drops exactly on the terminal count: no DONE.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("abort_at_terminal_no_done", done[0], 0);

    // Randomised phase.
    for (int k = 0; k < 600; k++) begin
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 15) != 0,
          $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
